// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: owns PC/IR, fetches 16-bit instructions and sequences the datapath control word.
// Optional macro CU_ILLEGAL_TRAP_EN: opcode F sets a sticky illegal flag and halts instead of acting as NOP.
module mc_control_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  output logic [7:0]      dmem_wdata,
  input  logic            dmem_valid,
  input  logic [7:0]      A_data,
  input  logic [7:0]      B_data,
  input  logic            Z,
  input  logic            N,
  output logic [2:0]      DA,
  output logic [2:0]      AA,
  output logic [2:0]      BA,
  output logic            TD,
  output logic            TA,
  output logic            TB,
  output logic            RW,
  output logic            MB,
  output logic            MD,
  output logic [3:0]      FS,
  output logic [7:0]      const_out,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MEMW, S_SW1, S_SW2, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_ADDI = 4'h6, OP_LDI  = 4'h7,
    OP_LD   = 4'h8, OP_ST   = 4'h9, OP_BRZ  = 4'hA, OP_BRN  = 4'hB,
    OP_JMP  = 4'hC, OP_SWAP = 4'hD, OP_HALT = 4'hE, OP_RSVD = 4'hF
  } opcode_t;

  localparam logic [3:0] FS_PASS_A = 4'b0000;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_SUB    = 4'b0101;
  localparam logic [3:0] FS_AND    = 4'b1000;
  localparam logic [3:0] FS_OR     = 4'b1001;
  localparam logic [3:0] FS_XOR    = 4'b1010;
  localparam logic [3:0] FS_PASS_B = 4'b1100;

  // Branch arithmetic is done wide enough for both PC and the 9-bit offset.
  localparam int SUM_W = (PC_W > 9) ? PC_W : 9;

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic [15:0]       r_ir;
  logic              r_imem_req;
  logic              w_fetch_ack;

  opcode_t           w_op;
  logic [2:0]        w_dr;
  logic [2:0]        w_sa;
  logic [2:0]        w_sb;
  logic [7:0]        w_imm;
  logic [8:0]        w_off9;
  logic [SUM_W-1:0]  w_br_sum;
  logic [PC_W-1:0]   w_br_target;
  logic [PC_W-1:0]   w_jmp_target;

  assign w_op   = opcode_t'(r_ir[15:12]);
  assign w_dr   = r_ir[11:9];
  assign w_sa   = r_ir[8:6];
  assign w_sb   = r_ir[5:3];
  assign w_imm  = {2'b00, r_ir[5:0]};
  assign w_off9 = {r_ir[11:9], r_ir[5:0]};

  // r_pc already points past the branch when EXEC runs.
  assign w_br_sum     = SUM_W'(r_pc) + SUM_W'($signed(w_off9));
  assign w_br_target  = w_br_sum[PC_W-1:0];
  assign w_jmp_target = PC_W'(A_data);

  assign w_fetch_ack = (r_state == S_FETCH) && r_imem_req && imem_valid;
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_illegal_set;
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    w_state_next = r_state;
    w_pc_next    = r_pc;
`ifdef CU_ILLEGAL_TRAP_EN
    w_illegal_set = 1'b0;
`endif
    DA         = w_dr;
    AA         = w_sa;
    BA         = w_sb;
    TD         = 1'b0;
    TA         = 1'b0;
    TB         = 1'b0;
    RW         = 1'b0;
    MB         = 1'b0;
    MD         = 1'b0;
    FS         = FS_PASS_A;
    const_out  = w_imm;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    halted     = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (w_fetch_ack) begin
          w_pc_next    = r_pc + PC_W'(1);
          w_state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        w_state_next = S_FETCH;
        case (w_op)
          OP_NOP:  ;
          OP_ADD:  begin RW = 1'b1; FS = FS_ADD; end
          OP_SUB:  begin RW = 1'b1; FS = FS_SUB; end
          OP_AND:  begin RW = 1'b1; FS = FS_AND; end
          OP_OR:   begin RW = 1'b1; FS = FS_OR;  end
          OP_XOR:  begin RW = 1'b1; FS = FS_XOR; end
          OP_ADDI: begin RW = 1'b1; MB = 1'b1; FS = FS_ADD;    end
          OP_LDI:  begin RW = 1'b1; MB = 1'b1; FS = FS_PASS_B; end
          OP_LD, OP_ST: w_state_next = S_MEMW;
          OP_BRZ:  if (Z) w_pc_next = w_br_target;
          OP_BRN:  if (N) w_pc_next = w_br_target;
          OP_JMP:  w_pc_next = w_jmp_target;
          OP_SWAP: begin
            // First leg parks Rd in the temp register R8.
            RW           = 1'b1;
            TD           = 1'b1;
            AA           = w_dr;
            w_state_next = S_SW1;
          end
          OP_HALT: w_state_next = S_HALT;
          OP_RSVD: begin
`ifdef CU_ILLEGAL_TRAP_EN
            w_illegal_set = 1'b1;
            w_state_next  = S_HALT;
`endif
          end
        endcase
      end

      S_MEMW: begin
        dmem_req   = 1'b1;
        dmem_we    = (w_op == OP_ST);
        dmem_addr  = A_data;
        dmem_wdata = B_data;
        if (dmem_valid) begin
          w_state_next = S_FETCH;
          if (w_op == OP_LD) begin
            RW = 1'b1;
            MD = 1'b1;
          end
        end
      end

      S_SW1: begin
        RW           = 1'b1;
        w_state_next = S_SW2;
      end

      S_SW2: begin
        RW           = 1'b1;
        DA           = w_sa;
        TA           = 1'b1;
        w_state_next = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_imem_req <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_imem_req <= (w_state_next == S_FETCH);
      if (w_fetch_ack) r_ir <= imem_rdata;
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_illegal <= 1'b0;
    else if (w_illegal_set) r_illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: directed instruction stream, expected fetch/write/memory events queued and
// popped by an independent negedge monitor.
module tb_mc_control_unit;

  localparam int PC_W = 8;

  localparam logic [1:0] EV_FETCH = 2'd0;
  localparam logic [1:0] EV_WRITE = 2'd1;
  localparam logic [1:0] EV_MEM   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [25:0] data;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid = 1'b0;
  logic [15:0]     imem_rdata = '0;
  logic            dmem_req;
  logic            dmem_we;
  logic [7:0]      dmem_addr;
  logic [7:0]      dmem_wdata;
  logic            dmem_valid = 1'b0;
  logic [7:0]      A_data = '0;
  logic [7:0]      B_data = '0;
  logic            Z = 1'b0;
  logic            N = 1'b0;
  logic [2:0]      DA, AA, BA;
  logic            TD, TA, TB, RW, MB, MD;
  logic [3:0]      FS;
  logic [7:0]      const_out;
  logic            halted;
  logic            illegal;

  int        n_checks = 0;
  int        n_errors = 0;
  ev_t       sb_q[$];
  logic [7:0] exp_pc;

  mc_control_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_valid(dmem_valid), .A_data(A_data), .B_data(B_data), .Z(Z), .N(N),
    .DA(DA), .AA(AA), .BA(BA), .TD(TD), .TA(TA), .TB(TB), .RW(RW), .MB(MB), .MD(MD),
    .FS(FS), .const_out(const_out), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] cw(input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                                     input logic td, input logic ta, input logic tb, input logic mb,
                                     input logic md, input logic [3:0] fs, input logic [7:0] k);
    return {da, aa, ba, td, ta, tb, mb, md, fs, k};
  endfunction

  task automatic push_ev(input logic [1:0] k, input logic [25:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] k, input logic [25:0] d, input string name);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected: got kind %0d data 0x%0h with empty scoreboard", name, k, d);
    end else begin
      e = sb_q.pop_front();
      check(name, {4'b0, k, d}, {4'b0, e.kind, e.data});
    end
  endtask

  // Monitor: sampled on the falling edge, independent of the stimulus thread.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_valid) observe(EV_FETCH, 26'(imem_addr), "fetch");
      if (dmem_req && dmem_valid) observe(EV_MEM, {9'b0, dmem_we, dmem_addr, dmem_wdata}, "mem");
      if (RW) observe(EV_WRITE, {DA, AA, BA, TD, TA, TB, MB, MD, FS, const_out}, "write");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Answers the next fetch request after d wait cycles; returns one step into EXEC.
  task automatic fetch(input logic [15:0] instr, input int d);
    int c = 0;
    while (!imem_req && c < 20) begin
      step();
      c++;
    end
    check("fetch_req_seen", 32'(imem_req), 32'd1);
    push_ev(EV_FETCH, 26'(exp_pc));
    for (int i = 0; i < d; i++) begin
      check("fetch_addr_hold", {23'b0, imem_req, imem_addr}, {23'b0, 1'b1, exp_pc});
      step();
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    step();
    imem_valid = 1'b0;
    imem_rdata = 16'hFFFF;
    exp_pc = exp_pc + 8'd1;
  endtask

  // Called in EXEC of LD/ST; dmem_valid arrives after d wait cycles.
  task automatic mem(input logic we, input int d);
    step();
    for (int i = 0; i < d; i++) begin
      check("dmem_wait", {29'b0, dmem_req, dmem_we, RW}, {29'b0, 1'b1, we, 1'b0});
      step();
    end
    check("dmem_valid_cycle", {30'b0, dmem_req, dmem_we}, {30'b0, 1'b1, we});
    dmem_valid = 1'b1;
    step();
    dmem_valid = 1'b0;
    check("dmem_released", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_pc = 8'h00;
    #1;
    check("rst_flags", {22'b0, imem_req, dmem_req, RW, TD, TA, TB, MB, MD, halted, illegal}, 32'd0);
    check("rst_ctrl", {11'b0, DA, AA, BA, FS, const_out}, 32'd0);
    check("rst_pc", 32'(imem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // LDI R1,5 with a 3-cycle fetch latency
    fetch(16'h7285, 3);
    push_ev(EV_WRITE, cw(3'd1, 3'd2, 3'd0, 0, 0, 0, 1, 0, 4'b1100, 8'h05));
    check("ldi_exec", {14'b0, RW, MB, FS, DA, const_out, imem_req},
          {14'b0, 1'b1, 1'b1, 4'b1100, 3'd1, 8'h05, 1'b0});
    step();

    // ADD R3,R1,R2
    fetch(16'h1650, 0);
    push_ev(EV_WRITE, cw(3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0, 4'b0010, 8'h10));
    check("add_exec", {26'b0, RW, MB, FS}, {26'b0, 1'b1, 1'b0, 4'b0010});
    step();
    check("add_back_to_fetch", 32'(imem_req), 32'd1);

    for (int i = 0; i < 3; i++) begin
      fetch(16'h0000, 0);
      check("nop_no_write", 32'(RW), 32'd0);
    end

    // BRZ at PC=5, offset -2, taken then not taken
    fetch(16'hAEBE, 0);
    Z = 1'b1;
    check("brz_exec", {24'b0, RW, FS, AA}, {24'b0, 1'b0, 4'b0000, 3'd2});
    exp_pc = 8'h04;
    step();
    Z = 1'b0;
    fetch(16'h0000, 1);
    fetch(16'hAEBE, 0);
    step();

    // BRN taken at PC=6 -> 5, then JMP to 0xFF and wrap to 0
    fetch(16'hBEBE, 1);
    N = 1'b1;
    exp_pc = 8'h05;
    step();
    N = 1'b0;
    fetch(16'hC040, 1);
    A_data = 8'hFF;
    exp_pc = 8'hFF;
    step();
    fetch(16'h0000, 1);

    // LD R4,[R1] with dmem_valid after 2 wait cycles
    fetch(16'h8840, 1);
    A_data = 8'h33;
    B_data = 8'h44;
    push_ev(EV_MEM, {9'b0, 1'b0, 8'h33, 8'h44});
    push_ev(EV_WRITE, cw(3'd4, 3'd1, 3'd0, 0, 0, 0, 0, 1, 4'b0000, 8'h00));
    mem(1'b0, 2);

    // ST M[R1]=R2 with one wait cycle
    fetch(16'h9050, 0);
    A_data = 8'h3A;
    B_data = 8'h5C;
    push_ev(EV_MEM, {9'b0, 1'b1, 8'h3A, 8'h5C});
    mem(1'b1, 1);

    // SWAP R1,R2
    fetch(16'hD288, 0);
    push_ev(EV_WRITE, cw(3'd1, 3'd1, 3'd1, 1, 0, 0, 0, 0, 4'b0000, 8'h08));
    push_ev(EV_WRITE, cw(3'd1, 3'd2, 3'd1, 0, 0, 0, 0, 0, 4'b0000, 8'h08));
    push_ev(EV_WRITE, cw(3'd2, 3'd2, 3'd1, 0, 1, 0, 0, 0, 4'b0000, 8'h08));
    check("swap_exec", {27'b0, RW, TD, AA}, {27'b0, 1'b1, 1'b1, 3'd1});
    step();
    check("swap_sw1", {23'b0, RW, DA, AA, TD, TA}, {23'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0});
    step();
    check("swap_sw2", {26'b0, RW, DA, TA, TD}, {26'b0, 1'b1, 3'd2, 1'b1, 1'b0});
    step();

    // Asynchronous reset in the middle of a fetch wait
    check("pre_reset_fetch", {23'b0, imem_req, imem_addr}, {23'b0, 1'b1, 8'h03});
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", {27'b0, imem_req, dmem_req, RW, halted, illegal}, 32'd0);
    check("async_rst_pc", 32'(imem_addr), 32'd0);
    step();
    rst_n = 1'b1;
    exp_pc = 8'h00;

    // Opcode F, then HALT
    fetch(16'hF000, 0);
    check("opf_no_write", 32'(RW), 32'd0);
    step();
`ifdef CU_ILLEGAL_TRAP_EN
    check("opf_trap", {29'b0, halted, illegal, imem_req}, {29'b0, 1'b1, 1'b1, 1'b0});
`else
    check("opf_as_nop", {30'b0, halted, illegal}, 32'd0);
    fetch(16'hE000, 0);
    step();
    check("halt_state", {29'b0, halted, illegal, imem_req}, {29'b0, 1'b1, 1'b0, 1'b0});
`endif

    // Stray handshakes while halted are ignored
    imem_valid = 1'b1;
    imem_rdata = 16'h7285;
    step();
    imem_valid = 1'b0;
    dmem_valid = 1'b1;
    step();
    dmem_valid = 1'b0;
    repeat (3) step();
    check("halt_stays", {28'b0, halted, imem_req, dmem_req, RW}, {28'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    rst_n = 1'b0;
    #1;
    check("halt_reset_flags", {29'b0, halted, illegal, imem_req}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_reset_fetch", {23'b0, imem_req, imem_addr}, {23'b0, 1'b1, 8'h00});

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle control unit sitting directly upstream of the 8-bit datapath; owns PC and IR and fetches 16-bit instructions from instruction memory.
Decodes each instruction and drives the datapath control word (DA/AA/BA/TD/TA/TB/RW/MB/MD/FS/const) one state per cycle.
Consumes the datapath's A_data, B_data, Z and N for branches, jumps and memory addressing, and sequences the data-memory handshake for load/store.

Parameters:
PC_W, 8, width of PC and of imem_addr.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_valid  in  1  instruction word valid, single-cycle pulse
imem_rdata  in  16  instruction word
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load (qualified by dmem_req)
dmem_addr  out  8  = A_data
dmem_wdata  out  8  = B_data
dmem_valid  in  1  load data valid / store done
A_data, B_data  in  8  datapath bus values
Z, N  in  1  datapath zero / negative flags (combinational)
DA, AA, BA  out  3  destination / A / B register addresses
TD, TA, TB  out  1  temp register (R8) selects
RW  out  1  register write enable
MB, MD  out  1  B-mux (1 = constant) / D-mux (1 = memory data)
FS  out  4  function select
const_out  out  8  immediate to datapath
halted  out  1  processor stopped
illegal  out  1  illegal opcode seen (feature only; else 0)

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, IR=0, state=FETCH, halted=0, illegal=0. All control outputs 0, including RW, TD/TA/TB, imem_req and dmem_req. Reset mid-handshake abandons the transaction.
- Instruction fields: op=[15:12], DR=[11:9], SA=[8:6], SB=[5:3], imm6=[5:0] zero-extended to 8 bits, off9={[11:9],[5:0]} sign-extended.
- Default control word in every state: RW=0, TD/TA/TB=0, MB=0, MD=0, FS=0000, DA=DR, AA=SA, BA=SB, const_out=imm6.
- States: FETCH, EXEC, MEMW, SW1, SW2, HALT.
- FETCH: imem_req=1, imem_addr=PC held stable until imem_valid. On imem_valid: IR<=imem_rdata, PC<=PC+1 (wraps modulo 2^PC_W), go to EXEC. imem_req deasserts the cycle after imem_valid.
- EXEC by opcode; all non-memory ops take one cycle and return to FETCH:
  - 0 NOP: nothing.
  - 1 ADD: RW=1, FS=0010.
  - 2 SUB: RW=1, FS=0101.
  - 3 AND: RW=1, FS=1000.
  - 4 OR: RW=1, FS=1001.
  - 5 XOR: RW=1, FS=1010.
  - 6 ADDI: RW=1, MB=1, FS=0010.
  - 7 LDI: RW=1, MB=1, FS=1100.
  - 8 LD, 9 ST: go to MEMW.
  - A BRZ / B BRN: FS=0000 (pass Ra); if Z (resp. N)=1 then PC<=PC+off9 (PC already incremented; truncated to PC_W).
  - C JMP: PC<=A_data zero-extended or truncated to PC_W.
  - D SWAP Rd,Ra: RW=1, TD=1, AA=DR, FS=0000 (R8<=Rd); go to SW1.
  - E HALT: go to HALT.
  - F: treated as NOP.
- MEMW: dmem_req=1, dmem_we=(op==9), dmem_addr=A_data, dmem_wdata=B_data, all held until dmem_valid. On the LD dmem_valid cycle: RW=1, MD=1 (write data_in into Rd). RW is 0 in every other MEMW cycle. Then go to FETCH.
- SW1: RW=1, DA=DR, AA=SA, FS=0000 (Rd<=Ra). Go to SW2.
- SW2: RW=1, DA=SA, TA=1, FS=0000 (Ra<=R8). Go to FETCH. SWAP Rd,Rd leaves Rd unchanged.
- HALT: halted=1; no requests issued; stays until reset.
- imem_valid or dmem_valid arriving in any state other than its waiting state is ignored.

Optional Feature:
CU_ILLEGAL_TRAP_EN: when defined, opcode F in EXEC sets illegal=1 (sticky until reset) and enters HALT. When undefined, opcode F behaves as NOP and illegal is tied to 0.

Test Plan:
- Reset, then fetch 0x7285 (LDI R1,5) with imem_valid delayed 3 cycles -> imem_addr=0 held for 3 cycles; in EXEC RW=1, DA=1, MB=1, FS=1100, const_out=0x05; PC=1.
- ADD R3,R1,R2 (0x1650) -> one EXEC cycle with RW=1, DA=3, AA=1, BA=2, FS=0010, MB=0; next state FETCH.
- BRZ R2 with off9=-2 at PC=5 (0xAE BE) and Z=1 -> next imem_addr=4; same instruction with Z=0 -> next imem_addr=6.
- LD R4,[R1] with dmem_valid after 2 cycles -> dmem_req=1, dmem_we=0 for 3 cycles; RW=1, MD=1, DA=4 only on the valid cycle.
- ST M[R1]=R2, then SWAP R1,R2 (0xD288) -> store held until dmem_valid; SWAP produces three RW pulses: TD=1, then DA=1/AA=2, then DA=2/TA=1.
- Opcode F, then HALT (0xE000), with rst_n pulsed mid-FETCH -> illegal/halted per macro setting; async reset clears all outputs immediately and PC returns to RESET_PC.
